// File: rtl/edl_final_motor_sensor_pio_if.sv
// Avalon-MM slave bus bundle shared by the motor PIO family.
// Zero wait states; readdata is valid in the same cycle as address.
interface edl_final_motor_sensor_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/edl_final_motor_sensor_pio.sv
// Sensor input PIO: synchronizes and debounces WIDTH asynchronous pins, latches
// qualifying debounced edges (RW1C) and raises a maskable level interrupt.
module edl_final_motor_sensor_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  edl_final_motor_sensor_pio_if.slave bus,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MASK = 2'd1,
    REG_RSVD = 2'd2,
    REG_EDGE = 2'd3
  } reg_sel_e;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] deb_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic [WIDTH-1:0] deb_update;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] w1c;
  reg_sel_e         reg_sel;
  logic             wr_en;
  logic             unused_wdata;

  assign reg_sel      = reg_sel_e'(bus.address);
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign w1c          = (wr_en && reg_sel == REG_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^bus.writedata;

  // A pin is accepted when it has disagreed with deb_q for DEBOUNCE_CYCLES
  // consecutive cycles; the edge direction is the newly accepted level.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    deb_update = '0;
    edge_event = '0;
    for (int i = 0; i < WIDTH; i++) begin
      deb_update[i] = (sync_q[i] != deb_q[i]) && (cnt_q[i] == CNT_LAST);
      if (EDGE_TYPE == 0) begin
        edge_event[i] = deb_update[i] & sync_q[i];
      end else if (EDGE_TYPE == 1) begin
        edge_event[i] = deb_update[i] & ~sync_q[i];
      end else begin
        edge_event[i] = deb_update[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta    <= '0;
      sync_q       <= '0;
      deb_q        <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      // NOTE: the counter array is real state, so each element is reset; a
      // stale partial count would shorten the first debounce after reset.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; a
      // blocking assignment would collapse the two synchronizer stages.
      sync_meta <= in_port;
      sync_q    <= sync_meta;

      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end

      if (wr_en && reg_sel == REG_MASK) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end

      // A new edge lands with its deb update and beats a same-cycle clear.
      edge_capture <= (edge_capture & ~w1c) | edge_event;
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (reg_sel)
      REG_DATA: bus.readdata[WIDTH-1:0] = deb_q;
      REG_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
      REG_EDGE: bus.readdata[WIDTH-1:0] = edge_capture;
      default:  bus.readdata            = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_edl_final_motor_sensor_pio.sv
// Scoreboard bench: three PIOs (any/rising/falling edge) share pins and bus;
// a window-based model predicts reads, a negedge monitor compares them.
module tb_edl_final_motor_sensor_pio;

  localparam int W = 4;
  localparam int D = 4;
  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   address;
  logic         cs;
  logic         write_n;
  logic [31:0]  wdata;
  logic [W-1:0] pins;
  logic         irq_a, irq_b, irq_c;
  logic [31:0]  rd_a, rd_b, rd_c;
  logic         smp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  edl_final_motor_sensor_pio_if bus_a ();
  edl_final_motor_sensor_pio_if bus_b ();
  edl_final_motor_sensor_pio_if bus_c ();

  assign bus_a.address = address;  assign bus_a.chipselect = cs;
  assign bus_a.write_n = write_n;  assign bus_a.writedata  = wdata;
  assign bus_b.address = address;  assign bus_b.chipselect = cs;
  assign bus_b.write_n = write_n;  assign bus_b.writedata  = wdata;
  assign bus_c.address = address;  assign bus_c.chipselect = cs;
  assign bus_c.write_n = write_n;  assign bus_c.writedata  = wdata;
  assign rd_a = bus_a.readdata;
  assign rd_b = bus_b.readdata;
  assign rd_c = bus_c.readdata;

  edl_final_motor_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .bus(bus_a), .in_port(pins), .irq(irq_a));
  edl_final_motor_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .bus(bus_b), .in_port(pins), .irq(irq_b));
  edl_final_motor_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .bus(bus_c), .in_port(pins), .irq(irq_c));

  // ---------------- reference model ----------------
  // A pin level is accepted at clock t when the D pin samples taken at clocks
  // t-D-1 .. t-2 all differ from the accepted level (two clocks of sync delay).
  bit [W-1:0] m_deb;
  bit [W-1:0] m_mask [NDUT];
  bit [W-1:0] m_edge [NDUT];
  bit [W-1:0] hist [$];

  function automatic bit edge_ok(int k, bit new_level);
    if (k == 0) return 1'b1;        // any
    else if (k == 1) return new_level;   // rising
    else return ~new_level;              // falling
  endfunction

  always @(posedge clk) begin
    bit [W-1:0] upd;
    bit         all_diff;
    bit [W-1:0] dropped;
    if (reset) begin
      m_deb = '0;
      for (int k = 0; k < NDUT; k++) begin
        m_mask[k] = '0;
        m_edge[k] = '0;
      end
      hist.delete();
      for (int j = 0; j < D + 2; j++) hist.push_back('0);
    end else begin
      hist.push_back(pins);
      while (hist.size() > D + 2) dropped = hist.pop_front();
      upd = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
        upd[b] = all_diff;
      end
      for (int k = 0; k < NDUT; k++) begin
        if (cs && !write_n) begin
          if (address == 2'd1) m_mask[k] = wdata[W-1:0];
          if (address == 2'd3) m_edge[k] = m_edge[k] & ~wdata[W-1:0];
        end
        for (int b = 0; b < W; b++)
          if (upd[b] && edge_ok(k, ~m_deb[b])) m_edge[k][b] = 1'b1;
      end
      m_deb = m_deb ^ upd;
    end
  end

  function automatic logic [31:0] model_read(int k, logic [1:0] a);
    case (a)
      2'd0:    return {{(32-W){1'b0}}, m_deb};
      2'd1:    return {{(32-W){1'b0}}, m_mask[k]};
      2'd3:    return {{(32-W){1'b0}}, m_edge[k]};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          dut;
    bit          is_irq;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq [$];

  task automatic check(string name, int dut, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, dut, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_value(int dut, bit is_irq);
    case (dut)
      0:       return is_irq ? {31'b0, irq_a} : rd_a;
      1:       return is_irq ? {31'b0, irq_b} : rd_b;
      default: return is_irq ? {31'b0, irq_c} : rd_c;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (smp) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected >0 (t=%0t)", $time);
      end
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.name, e.dut, dut_value(e.dut, e.is_irq), e.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_model(string name);
    for (int k = 0; k < NDUT; k++) begin
      sbq.push_back('{name, k, 1'b0, model_read(k, address)});
      sbq.push_back('{{name, "_irq"}, k, 1'b1, {31'b0, |(m_edge[k] & m_mask[k])}});
    end
  endtask

  // Called right after a posedge: sample at the following negedge, then
  // return just after the next posedge.
  task automatic sample_go();
    smp = 1'b1;
    @(negedge clk);
    #1 smp = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [1:0] a, string name);
    address = a; cs = 1'b1; write_n = 1'b1;
    push_model(name);
    sample_go();
    cs = 1'b0;
  endtask

  task automatic rd_const(int dut, logic [1:0] a, string name, logic [31:0] exp_rd, bit exp_irq);
    address = a; cs = 1'b1; write_n = 1'b1;
    sbq.push_back('{{name, "_const"}, dut, 1'b0, exp_rd});
    sbq.push_back('{{name, "_const_irq"}, dut, 1'b1, {31'b0, exp_irq}});
    push_model(name);
    sample_go();
    cs = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a; cs = 1'b1; write_n = 1'b0; wdata = d;
    tick(1);
    cs = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = '0; cs = 1'b0; write_n = 1'b1; wdata = '0; pins = '0;
    tick(2);
    reset = 1'b0;

    for (int a = 0; a < 4; a++) rd_const(0, 2'(a), "reset_state", 32'h0, 1'b0);

    // Pin 0 raised and held: DATA through clock 5 is 0, from clock 6 is 1.
    pins[0] = 1'b1;
    tick(1);
    for (int k = 1; k <= 8; k++) rd_const(0, 2'd0, "t1_latency", (k >= 6) ? 32'h1 : 32'h0, 1'b0);
    rd_const(0, 2'd3, "t1_edge", 32'h1, 1'b0);
    wr(2'd3, 32'hF);

    // 3-clock glitch on pin 1 never reaches DATA or EDGE.
    pins[1] = 1'b1; tick(3); pins[1] = 1'b0;
    for (int k = 0; k < 8; k++) rd_const(0, 2'd0, "t2_glitch_data", 32'h1, 1'b0);
    rd_const(0, 2'd3, "t2_glitch_edge", 32'h0, 1'b0);
    // 4-clock pulse is accepted.
    pins[1] = 1'b1; tick(4); pins[1] = 1'b0;
    tick(2);
    rd_const(0, 2'd0, "t2_pulse_data", 32'h3, 1'b0);
    rd_const(0, 2'd3, "t2_pulse_edge", 32'h2, 1'b0);
    tick(6);
    wr(2'd3, 32'hF);

    // Mask, W1C and irq.
    wr(2'd1, 32'h3);
    pins[1] = 1'b1; tick(8);
    rd_const(0, 2'd3, "t3_edge_irq", 32'h2, 1'b1);
    wr(2'd3, 32'h2);
    rd_const(0, 2'd3, "t3_w1c", 32'h0, 1'b0);
    pins[1] = 1'b0; tick(8);
    wr(2'd3, 32'h1);
    rd_const(0, 2'd3, "t3_w1c_other_bit", 32'h2, 1'b1);
    wr(2'd1, 32'h0);
    rd_const(0, 2'd3, "t3_mask_drop", 32'h2, 1'b0);
    wr(2'd1, 32'h3);
    rd_const(0, 2'd1, "t3_unmask", 32'h3, 1'b1);
    wr(2'd3, 32'hF);

    // W1C of bit 2 lands on the same clock as pin 2's debounced edge.
    pins[2] = 1'b1;
    tick(5);
    wr(2'd3, 32'h4);
    rd_const(0, 2'd3, "t4_set_wins", 32'h4, 1'b0);
    wr(2'd3, 32'hF);

    // Falling edge on pin 3: rising-only unit stays clear, falling-only sets.
    pins[3] = 1'b1; tick(8);
    wr(2'd3, 32'hF);
    pins[3] = 1'b0; tick(8);
    rd_const(0, 2'd0, "t5_data", 32'h5, 1'b0);
    rd_const(1, 2'd3, "t5_rise_only", 32'h0, 1'b0);
    rd_const(2, 2'd3, "t5_fall_only", 32'h8, 1'b0);

    // Reset mid-count, with a same-cycle MASK write that must lose.
    wr(2'd3, 32'hF);
    wr(2'd1, 32'hF);
    pins[0] = 1'b0; pins[2] = 1'b0; tick(8);
    rd_const(0, 2'd3, "t6_pre", 32'h5, 1'b1);
    pins[1] = 1'b1; tick(3);
    reset = 1'b1; address = 2'd1; cs = 1'b1; write_n = 1'b0; wdata = 32'hF;
    tick(1);
    reset = 1'b0; cs = 1'b0; write_n = 1'b1;
    for (int a = 0; a < 4; a++) rd_const(0, 2'(a), "t6_after_reset", 32'h0, 1'b0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd_const(0, 2'd2, "t6_rsvd", 32'h0, 1'b0);
    tick(10);
    rd_const(0, 2'd0, "t6_restart", 32'h2, 1'b0);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 6) begin
        pins = pins ^ W'($urandom);
        tick($urandom_range(1, 6));
      end else if (r < 10) begin
        wr(2'($urandom_range(0, 3)), $urandom);
      end else if (r < 18) begin
        rd(2'($urandom_range(0, 3)), "rand_rd");
      end else if (r == 18 && $urandom_range(0, 3) == 0) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end else begin
        tick(1);
      end
    end
    for (int a = 0; a < 4; a++) rd(2'(a), "final_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
